// File: rtl/ava_alu_slave_if.sv
// Avalon-MM slave bus bundle for the ALU peripheral: 32-bit data, word addressed.
interface ava_alu_slave_if;
  logic [2:0]  slave_address;
  logic        slave_write;
  logic        slave_read;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        slave_waitrequest;

  modport master (
    output slave_address, slave_write, slave_read, slave_byteenable, slave_writedata,
    input  slave_readdata, slave_waitrequest
  );

  modport slave (
    input  slave_address, slave_write, slave_read, slave_byteenable, slave_writedata,
    output slave_readdata, slave_waitrequest
  );
endinterface

// File: rtl/ava_alu_slave.sv
// Avalon-MM ALU peripheral: operand/control/status/result registers, one op per start,
// multi-cycle shift-add MUL, wait-stated reads. Optional interrupt via AVA_ALU_IRQ_EN.
module ava_alu_slave #(
  parameter int READ_WAIT = 1,
  parameter int MUL_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  ava_alu_slave_if.slave   bus
`ifdef AVA_ALU_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int MUL_CYC = 32 / MUL_BITS;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [31:0] opa_r, opb_r;
  logic [2:0]  op_r, op_x_r, op_new_s;
  logic [63:0] mca_r, acc_r, acc_nx_s, res_s;
  logic [31:0] mpb_r, sum_s, dif_s, rmux_s;
  logic [4:0]  cnt_r;
  logic [31:0] res_lo_r, res_hi_r, rdata_r;
  logic        done_r, ovf_r, ovf_s, irq_en_s;
  logic [2:0]  rd_cnt_r;
  logic        busy_s, wr_s, rd_s, start_req_s, stall_s, wr_acc_s, start_s;
  logic        clr_done_s, last_s, rd_cap_s, rd_done_s;

  assign busy_s      = (state_r == ST_EXEC);
  assign wr_s        = bus.slave_write;
  assign rd_s        = bus.slave_read & ~bus.slave_write;
  assign start_req_s = wr_s & (bus.slave_address == 3'd2) & bus.slave_byteenable[1]
                       & bus.slave_writedata[8];
  assign stall_s     = start_req_s & busy_s;
  assign wr_acc_s    = wr_s & ~stall_s;
  assign start_s     = start_req_s & ~busy_s;
  assign clr_done_s  = wr_acc_s & (bus.slave_address == 3'd3) & bus.slave_writedata[1];
  assign op_new_s    = bus.slave_byteenable[0] ? bus.slave_writedata[2:0] : op_r;
  // The last wait cycle captures readdata so it is valid on the wait-free cycle.
  assign rd_cap_s    = rd_s & (rd_cnt_r == 3'(READ_WAIT - 1));
  assign rd_done_s   = rd_s & (rd_cnt_r == 3'(READ_WAIT));

  assign bus.slave_waitrequest = stall_s | (rd_s & ~rd_done_s);
  assign bus.slave_readdata    = rdata_r;

`ifdef AVA_ALU_IRQ_EN
  logic irq_en_r, irq_r;

  // Interrupt enable bit and registered interrupt output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      if (wr_acc_s && (bus.slave_address == 3'd2) && bus.slave_byteenable[2]) begin
        irq_en_r <= bus.slave_writedata[16];
      end
      irq_r <= done_r & irq_en_r;
    end
  end

  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign irq_en_s = 1'b0;
`endif

  // Host-writable operand and op registers with byte-lane enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa_r <= 32'd0;
      opb_r <= 32'd0;
      op_r  <= 3'd0;
    end else if (wr_acc_s) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.slave_byteenable[i] && (bus.slave_address == 3'd0)) begin
          opa_r[8*i +: 8] <= bus.slave_writedata[8*i +: 8];
        end
        if (bus.slave_byteenable[i] && (bus.slave_address == 3'd1)) begin
          opb_r[8*i +: 8] <= bus.slave_writedata[8*i +: 8];
        end
      end
      if ((bus.slave_address == 3'd2) && bus.slave_byteenable[0]) begin
        op_r <= bus.slave_writedata[2:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; last_s marks the final EXEC cycle.
  always_comb begin
    state_s = state_r;
    last_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_EXEC;
        else         state_s = ST_IDLE;
      end
      ST_EXEC: begin
        if ((op_x_r != 3'd7) || (cnt_r == 5'(MUL_CYC - 1))) begin
          last_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_EXEC;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // ALU result and overflow from the snapshotted operands.
  always_comb begin
    acc_nx_s = acc_r;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (mpb_r[i]) acc_nx_s = acc_nx_s + (mca_r << i);
      else          acc_nx_s = acc_nx_s;
    end
    sum_s = mca_r[31:0] + mpb_r;
    dif_s = mca_r[31:0] - mpb_r;
    res_s = 64'd0;
    ovf_s = 1'b0;
    case (op_x_r)
      3'd0: begin
        res_s = {32'd0, sum_s};
        ovf_s = (mca_r[31] == mpb_r[31]) & (sum_s[31] != mca_r[31]);
      end
      3'd1: begin
        res_s = {32'd0, dif_s};
        ovf_s = (mca_r[31] != mpb_r[31]) & (dif_s[31] != mca_r[31]);
      end
      3'd2: res_s = {32'd0, mca_r[31:0] & mpb_r};
      3'd3: res_s = {32'd0, mca_r[31:0] | mpb_r};
      3'd4: res_s = {32'd0, mca_r[31:0] ^ mpb_r};
      3'd5: res_s = {32'd0, mca_r[31:0] << mpb_r[4:0]};
      3'd6: res_s = {32'd0, mca_r[31:0] >> mpb_r[4:0]};
      3'd7: begin
        res_s = acc_nx_s;
        ovf_s = |acc_nx_s[63:32];
      end
      default: begin
        res_s = 64'd0;
        ovf_s = 1'b0;
      end
    endcase
  end

  // Operand snapshot on start, then shift-add stepping while executing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mca_r  <= 64'd0;
      mpb_r  <= 32'd0;
      acc_r  <= 64'd0;
      cnt_r  <= 5'd0;
      op_x_r <= 3'd0;
    end else if (start_s) begin
      mca_r  <= {32'd0, opa_r};
      mpb_r  <= opb_r;
      acc_r  <= 64'd0;
      cnt_r  <= 5'd0;
      op_x_r <= op_new_s;
    end else if (busy_s) begin
      acc_r <= acc_nx_s;
      mca_r <= mca_r << MUL_BITS;
      mpb_r <= mpb_r >> MUL_BITS;
      cnt_r <= cnt_r + 5'd1;
    end
  end

  // Result and status registers; a completing op beats a same-edge done clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_lo_r <= 32'd0;
      res_hi_r <= 32'd0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (last_s) begin
        res_lo_r <= res_s[31:0];
        res_hi_r <= res_s[63:32];
        ovf_r    <= ovf_s;
      end
      if (last_s)                      done_r <= 1'b1;
      else if (start_s || clr_done_s)  done_r <= 1'b0;
    end
  end

  // Register read mux.
  always_comb begin
    rmux_s = 32'd0;
    case (bus.slave_address)
      3'd0:    rmux_s = opa_r;
      3'd1:    rmux_s = opb_r;
      3'd2:    rmux_s = {15'd0, irq_en_s, 13'd0, op_r};
      3'd3:    rmux_s = {29'd0, ovf_r, done_r, busy_s};
      3'd4:    rmux_s = res_lo_r;
      3'd5:    rmux_s = res_hi_r;
      default: rmux_s = 32'd0;
    endcase
  end

  // Read wait-state counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_r <= 3'd0;
      rdata_r  <= 32'd0;
    end else if (rd_s) begin
      if (rd_done_s) rd_cnt_r <= 3'd0;
      else           rd_cnt_r <= rd_cnt_r + 3'd1;
      if (rd_cap_s)  rdata_r  <= rmux_s;
    end else begin
      rd_cnt_r <= 3'd0;
    end
  end

endmodule

// File: tb/tb_ava_alu_slave.sv
// Self-checking bench for ava_alu_slave: directed cases plus randomized ops against a reference model.
`timescale 1ns/1ps
module tb_ava_alu_slave;

  localparam int RW  = 1;
  localparam int MB  = 1;
  localparam int LAT = 32 / MB;
  localparam longint MAX32 = 64'sd2147483647;
  localparam longint MIN32 = -64'sd2147483648;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ava_alu_slave_if bus();
`ifdef AVA_ALU_IRQ_EN
  logic irq;
`endif

  ava_alu_slave #(.READ_WAIT(RW), .MUL_BITS(MB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef AVA_ALU_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, hi, lo} computed from the op definitions with wide arithmetic.
  function automatic logic [64:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin r = sa + sb; return {(r > MAX32) || (r < MIN32), 32'd0, a + b}; end
      3'd1: begin r = sa - sb; return {(r > MAX32) || (r < MIN32), 32'd0, a - b}; end
      3'd2: return {1'b0, 32'd0, a & b};
      3'd3: return {1'b0, 32'd0, a | b};
      3'd4: return {1'b0, 32'd0, a ^ b};
      3'd5: return {1'b0, 32'd0, a << b[4:0]};
      3'd6: return {1'b0, 32'd0, a >> b[4:0]};
      default: begin
        p = {32'd0, a} * {32'd0, b};
        return {p[63:32] != 32'd0, p};
      end
    endcase
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int stalls);
    @(posedge clk); #1;
    bus.slave_address = a; bus.slave_writedata = d; bus.slave_byteenable = be;
    bus.slave_write = 1'b1;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!bus.slave_waitrequest) break;
      stalls++;
      if (stalls > 200) begin check("wr_timeout", 64'd1, 64'd0); break; end
    end
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    int s;
    bus_write(a, d, be, s);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    int waits = 0;
    @(posedge clk); #1;
    bus.slave_address = a; bus.slave_read = 1'b1;
    while (1) begin
      @(negedge clk);
      if (!bus.slave_waitrequest) break;
      waits++;
      if (waits > 50) break;
    end
    d = bus.slave_readdata;
    check("rd_wait", 64'(waits), 64'(RW));
    @(posedge clk); #1;
    bus.slave_read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, {32'd0, d}, {32'd0, exp});
  endtask

  task automatic wait_done();
    logic [31:0] st;
    int n = 0;
    st = 32'd0;
    while (n < 100) begin
      rd(3'd3, st);
      if (st[1]) break;
      n++;
    end
    if (!st[1]) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_ref(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    e = ref_alu(op, a, b);
    wr(3'd0, a, 4'hF);
    wr(3'd1, b, 4'hF);
    wr(3'd2, 32'h100 | {29'd0, op}, 4'b0011);
    wait_done();
    rd_chk({tag, "_lo"}, 3'd4, e[31:0]);
    rd_chk({tag, "_hi"}, 3'd5, e[63:32]);
    rd_chk({tag, "_st"}, 3'd3, {29'd0, e[64], 2'b10});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    logic [31:0] d;
    bus.slave_address = 3'd0; bus.slave_write = 1'b0; bus.slave_read = 1'b0;
    bus.slave_byteenable = 4'h0; bus.slave_writedata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdata", {32'd0, bus.slave_readdata}, 64'd0);
    check("rst_wait", {63'd0, bus.slave_waitrequest}, 64'd0);
    reset_n = 1'b1;
    rd_chk("rst_status", 3'd3, 32'd0);
    rd_chk("rst_reslo", 3'd4, 32'd0);

    // Basic ADD and signed-overflow edges.
    run_ref("add_5_7", 3'd0, 32'd5, 32'd7);
    rd_chk("add_5_7_val", 3'd4, 32'd12);
    run_ref("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'd1);
    rd_chk("add_ovf_val", 3'd4, 32'h8000_0000);
    run_ref("sub_0_1", 3'd1, 32'd0, 32'd1);
    rd_chk("sub_0_1_val", 3'd4, 32'hFFFF_FFFF);

    // MUL with an OPA write while it runs.
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd1, 32'd2, 4'hF);
    wr(3'd2, 32'h107, 4'hF);
    wr(3'd0, 32'd3, 4'hF);
    wait_done();
    rd_chk("mul_lo", 3'd4, 32'hFFFF_FFFE);
    rd_chk("mul_hi", 3'd5, 32'd1);
    rd_chk("mul_st", 3'd3, 32'h6);
    rd_chk("mul_opa", 3'd0, 32'd3);

    // Start during MUL stalls until idle, then the queued ADD runs on 3 and 2.
    wr(3'd2, 32'h107, 4'hF);
    bus_write(3'd2, 32'h100, 4'b0011, s);
    check("stall_len", 64'(s), 64'(LAT - 1));
    wait_done();
    rd_chk("queued_lo", 3'd4, 32'd5);
    rd_chk("queued_hi", 3'd5, 32'd0);

    // Byte-lane writes.
    wr(3'd0, 32'd0, 4'hF);
    wr(3'd0, 32'hAABB_CCDD, 4'b0001);
    rd_chk("be_opa", 3'd0, 32'h0000_00DD);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd1, 32'hAABB_CCDD, 4'b1100);
    rd_chk("be_opb", 3'd1, 32'hAABB_0000);

    // CTRL lanes: op only via be[0], start only via be[1].
    wr(3'd2, 32'd4, 4'b0001);
    wr(3'd0, 32'h0000_F0F0, 4'hF);
    wr(3'd1, 32'h0000_0FF0, 4'hF);
    wr(3'd2, 32'h107, 4'b0010);
    wait_done();
    rd_chk("lane_xor", 3'd4, 32'h0000_FF00);
    rd_chk("lane_ctrl", 3'd2, 32'd4);
    wr(3'd2, 32'h100, 4'b0001);
    rd_chk("lane_nostart_ctrl", 3'd2, 32'd0);
    rd_chk("lane_nostart_res", 3'd4, 32'h0000_FF00);

    // Unmapped addresses.
    wr(3'd6, 32'h1234_5678, 4'hF);
    rd_chk("addr6", 3'd6, 32'd0);
    rd_chk("addr7", 3'd7, 32'd0);

    // Simultaneous read and write acts as a write with no wait.
    @(posedge clk); #1;
    bus.slave_address = 3'd0; bus.slave_writedata = 32'h0BAD_F00D; bus.slave_byteenable = 4'hF;
    bus.slave_write = 1'b1; bus.slave_read = 1'b1;
    @(negedge clk);
    check("rw_wait", {63'd0, bus.slave_waitrequest}, 64'd0);
    @(posedge clk); #1;
    bus.slave_write = 1'b0; bus.slave_read = 1'b0;
    rd_chk("rw_opa", 3'd0, 32'h0BAD_F00D);

    // W1C clear, then done-set and W1C on the same edge.
    wr(3'd3, 32'h2, 4'hF);
    rd_chk("w1c", 3'd3, 32'h0);
    @(posedge clk); #1;
    bus.slave_address = 3'd2; bus.slave_writedata = 32'h100; bus.slave_byteenable = 4'hF;
    bus.slave_write = 1'b1;
    @(posedge clk); #1;
    bus.slave_address = 3'd3; bus.slave_writedata = 32'h2;
    @(posedge clk); #1;
    bus.slave_write = 1'b0;
    rd_chk("set_wins", 3'd3, 32'h2);

    // Randomized ops against the reference model.
    for (int i = 0; i < 24; i++) begin
      run_ref($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
    end

`ifdef AVA_ALU_IRQ_EN
    wr(3'd2, 32'h0001_0100, 4'hF);
    wait_done();
    @(negedge clk); @(negedge clk);
    check("irq_set", {63'd0, irq}, 64'd1);
    rd_chk("irq_ctrl", 3'd2, 32'h0001_0000);
    wr(3'd3, 32'h2, 4'hF);
    @(posedge clk); @(negedge clk);
    check("irq_clr", {63'd0, irq}, 64'd0);
`else
    wr(3'd2, 32'h0001_0000, 4'hF);
    rd_chk("no_irq_ctrl", 3'd2, 32'd0);
`endif

    // Reset in the middle of a MUL.
    wr(3'd0, 32'h1234_5678, 4'hF);
    wr(3'd1, 32'd9, 4'hF);
    rd_chk("pre_rst_opa", 3'd0, 32'h1234_5678);
    wr(3'd2, 32'h107, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rdata", {32'd0, bus.slave_readdata}, 64'd0);
    check("mid_rst_wait", {63'd0, bus.slave_waitrequest}, 64'd0);
`ifdef AVA_ALU_IRQ_EN
    check("mid_rst_irq", {63'd0, irq}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("post_rst_status", 3'd3, 32'd0);
    rd_chk("post_rst_reslo", 3'd4, 32'd0);
    rd_chk("post_rst_opa", 3'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
